// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-beat instruction fetch with decode handshake, PC control and fault halt.
// One request outstanding at most; redirects win over every other event in the cycle.
module instr_fetch_unit #(
    parameter logic [31:0] IMEM_BASE  = 32'h0100_0000,
    parameter logic [31:0] IMEM_LIMIT = 32'h0100_0FFC,
    parameter int          TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] instr_addr,
    input  logic        halt,
    output logic        pc_we,
    output logic        pc_imm,
    output logic [31:0] pc_imm_addr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fault,
    output logic [1:0]  fault_cause
);
    typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_HALTED} state_t;

    state_t     state, state_n;
    logic [7:0] cnt;
    logic [1:0] cause;
    logic       redir_ok, redir_bad, in_range, timed_out, active;

    assign redir_ok  = redirect_valid && redirect_addr[1:0] == 2'b00;
    assign redir_bad = redirect_valid && redirect_addr[1:0] != 2'b00;
    assign in_range  = instr_addr >= IMEM_BASE && instr_addr <= IMEM_LIMIT;
    assign timed_out = cnt == 8'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= S_REQ;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        cause   = 2'd0;
        if (redir_bad && state != S_HALTED) begin
            state_n = S_HALTED;
            cause   = 2'd2;
        end else begin
            case (state)
                S_REQ: begin
                    if (redir_ok)
                        state_n = S_REQ;
                    else if (halt)
                        state_n = S_HALTED;
                    else if (!in_range) begin
                        state_n = S_HALTED;
                        cause   = 2'd1;
                    end else
                        state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (redir_ok)
                        state_n = imem_rvalid ? S_REQ : S_DRAIN;
                    else if (imem_rvalid) begin
                        state_n = imem_err ? S_HALTED : S_HOLD;
                        cause   = imem_err ? 2'd3 : 2'd0;
                    end else if (timed_out) begin
                        state_n = S_HALTED;
                        cause   = 2'd3;
                    end
                end
                S_HOLD: state_n = (redir_ok || if_ready) ? S_REQ : S_HOLD;
                S_DRAIN: begin
                    if (imem_rvalid)
                        state_n = S_REQ;
                    else if (timed_out) begin
                        state_n = S_HALTED;
                        cause   = 2'd3;
                    end
                end
                default: state_n = S_HALTED;
            endcase
        end
    end

    // Outputs are forced low while rstn is asserted so reset looks clean on the pins.
    always_comb begin
        active      = rstn && state != S_HALTED;
        pc_we       = active && (redir_ok || (state == S_HOLD && if_valid && if_ready));
        pc_imm      = active && redir_ok;
        pc_imm_addr = pc_imm ? redirect_addr : 32'd0;
        imem_req    = rstn && state == S_REQ && !redirect_valid && !halt && in_range;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            imem_addr   <= IMEM_BASE;
            cnt         <= 8'd0;
            if_valid    <= 1'b0;
            if_instr    <= 32'd0;
            if_pc       <= 32'd0;
            fault       <= 1'b0;
            fault_cause <= 2'd0;
        end else begin
            if (imem_req)
                imem_addr <= instr_addr;
            cnt <= state == S_REQ ? 8'd0 : (state == S_WAIT || state == S_DRAIN) ? cnt + 8'd1 : cnt;
            if (state == S_WAIT && state_n == S_HOLD) begin
                if_instr <= imem_rdata;
                if_pc    <= imem_addr;
                if_valid <= 1'b1;
            end
            if (state == S_HOLD && state_n != S_HOLD)
                if_valid <= 1'b0;
            if (state != S_HALTED && state_n == S_HALTED && cause != 2'd0) begin
                fault       <= 1'b1;
                fault_cause <= cause;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed boundary checks, then a randomized run against a
// program-order model (PC, memory and decode live in the bench).
module tb_instr_fetch_unit;
    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam logic [31:0] LIMIT = 32'h0100_0FFC;
    localparam int          TO    = 16;

    logic        clk = 1'b0, rstn = 1'b0;
    logic [31:0] instr_addr = BASE, pc_imm_addr, redirect_addr = '0, imem_addr, imem_rdata = '0;
    logic [31:0] if_instr, if_pc;
    logic        halt = 1'b0, pc_we, pc_imm, redirect_valid = 1'b0, imem_req, imem_rvalid = 1'b0;
    logic        imem_err = 1'b0, if_valid, if_ready = 1'b0, fault;
    logic [1:0]  fault_cause;
    int          n_cmp = 0, n_bad = 0;

    instr_fetch_unit #(.IMEM_BASE(BASE), .IMEM_LIMIT(LIMIT), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .instr_addr(instr_addr), .halt(halt),
        .pc_we(pc_we), .pc_imm(pc_imm), .pc_imm_addr(pc_imm_addr),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .imem_err(imem_err), .if_valid(if_valid),
        .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .fault(fault), .fault_cause(fault_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic idle();
        halt = 0; redirect_valid = 0; imem_rvalid = 0; imem_err = 0; if_ready = 0;
    endtask

    // Returns in the first post-reset cycle (the REQ cycle) with addr/halt applied.
    task automatic reset_dut(input logic [31:0] a, input logic h, input logic exp_req);
        @(negedge clk);
        rstn = 0;
        idle();
        @(negedge clk);
        #1;
        chk("rst_if_valid", 32'(if_valid), 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_pc_we", 32'(pc_we), 0);
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_imem_addr", imem_addr, BASE);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_cause", 32'(fault_cause), 0);
        instr_addr = a;
        halt = h;
        rstn = 1;
        #1 chk("first_req", 32'(imem_req), 32'(exp_req));
    endtask

    logic [31:0] pc, exp_pc, req_addr;
    logic        pending, was_pending, chk_addr, acc;
    int          dly, n_acc;

    initial begin
        // sequential fetch, 1-cycle memory
        reset_dut(BASE, 0, 1);
        if_ready = 1;
        @(negedge clk);
        chk("seq_addr", imem_addr, BASE);
        imem_rvalid = 1; imem_rdata = 32'h13;
        #1 chk("seq_not_yet", 32'(if_valid), 0);
        @(negedge clk);
        imem_rvalid = 0;
        #1;
        chk("seq_valid", 32'(if_valid), 1);
        chk("seq_pc", if_pc, BASE);
        chk("seq_instr", if_instr, 32'h13);
        chk("seq_we", 32'(pc_we), 1);
        chk("seq_imm", 32'(pc_imm), 0);
        instr_addr = BASE + 4;
        @(negedge clk);
        #1;
        chk("seq_req2", 32'(imem_req), 1);
        chk("seq_we_off", 32'(pc_we), 0);
        @(negedge clk);
        chk("seq_addr2", imem_addr, BASE + 4);
        // backpressure
        if_ready = 0; imem_rvalid = 1; imem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        imem_rvalid = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_instr", if_instr, 32'hCAFE_0001);
            chk("bp_pc", if_pc, BASE + 4);
            chk("bp_we", 32'(pc_we), 0);
            @(negedge clk);
        end
        if_ready = 1;
        #1 chk("bp_release_we", 32'(pc_we), 1);
        instr_addr = BASE + 8;
        @(negedge clk);
        #1;
        chk("bp_single_pulse", 32'(pc_we), 0);
        chk("bp_req", 32'(imem_req), 1);
        // redirect during WAIT, stale response 3 cycles later
        @(negedge clk);
        chk("rd_addr", imem_addr, BASE + 8);
        redirect_valid = 1; redirect_addr = BASE + 32'h100;
        #1;
        chk("rd_we", 32'(pc_we), 1);
        chk("rd_imm", 32'(pc_imm), 1);
        chk("rd_target", pc_imm_addr, BASE + 32'h100);
        instr_addr = BASE + 32'h100;
        @(negedge clk);
        redirect_valid = 0;
        #1 chk("rd_drain_noreq", 32'(imem_req), 0);
        @(negedge clk);
        @(negedge clk);
        imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0;
        #1 chk("rd_drain_nvalid", 32'(if_valid), 0);
        @(negedge clk);
        imem_rvalid = 0;
        #1;
        chk("rd_no_stale", 32'(if_valid), 0);
        chk("rd_req", 32'(imem_req), 1);
        @(negedge clk);
        chk("rd_new_addr", imem_addr, BASE + 32'h100);
        if_ready = 0; imem_rvalid = 1; imem_rdata = 32'h77;
        @(negedge clk);
        imem_rvalid = 0;
        #1 chk("rd_instr", if_instr, 32'h77);
        // misaligned redirect while holding
        redirect_valid = 1; redirect_addr = BASE + 32'h102;
        #1 chk("mis_no_we", 32'(pc_we), 0);
        @(negedge clk);
        redirect_valid = 0;
        #1;
        chk("mis_fault", 32'(fault), 1);
        chk("mis_cause", 32'(fault_cause), 2);
        chk("mis_valid", 32'(if_valid), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            redirect_valid = 1; redirect_addr = BASE; if_ready = 1;
            #1;
            chk("halted_req", 32'(imem_req), 0);
            chk("halted_we", 32'(pc_we), 0);
        end
        // timeout: 16 wait cycles allowed
        reset_dut(BASE, 0, 1);
        repeat (15) @(negedge clk);
        @(negedge clk);
        #1 chk("to_not_yet", 32'(fault), 0);
        @(negedge clk);
        #1;
        chk("to_fault", 32'(fault), 1);
        chk("to_cause", 32'(fault_cause), 3);
        // bus error
        reset_dut(BASE, 0, 1);
        @(negedge clk);
        imem_rvalid = 1; imem_err = 1; imem_rdata = 32'h1234;
        @(negedge clk);
        imem_rvalid = 0; imem_err = 0;
        #1;
        chk("err_cause", 32'(fault_cause), 3);
        chk("err_valid", 32'(if_valid), 0);
        // range limits
        reset_dut(LIMIT, 0, 1);
        reset_dut(BASE + 32'h1000, 0, 0);
        @(negedge clk);
        #1;
        chk("rng_hi_fault", 32'(fault), 1);
        chk("rng_hi_cause", 32'(fault_cause), 1);
        chk("rng_hi_req", 32'(imem_req), 0);
        reset_dut(BASE - 4, 0, 0);
        @(negedge clk);
        #1 chk("rng_lo_cause", 32'(fault_cause), 1);
        // halt without fault
        reset_dut(BASE, 1, 0);
        @(negedge clk);
        halt = 0;
        #1;
        chk("halt_fault", 32'(fault), 0);
        chk("halt_req", 32'(imem_req), 0);
        // reset in the middle of a held instruction
        reset_dut(BASE, 0, 1);
        @(negedge clk);
        imem_rvalid = 1; imem_rdata = 32'h55;
        @(negedge clk);
        imem_rvalid = 0;
        #1 chk("mid_valid", 32'(if_valid), 1);

        // randomized run: bench owns the PC, memory and decode
        reset_dut(BASE, 0, 1);
        pc = BASE; exp_pc = BASE; req_addr = BASE; pending = 1; chk_addr = 1;
        dly = $urandom_range(0, 3); n_acc = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (chk_addr) chk("r_imem_addr", imem_addr, req_addr);
            chk_addr = 0;
            instr_addr = pc;
            imem_rvalid = 0; imem_rdata = $urandom;
            was_pending = pending;
            if (pending) begin
                if (dly == 0) begin
                    imem_rvalid = 1; imem_rdata = word_at(req_addr); pending = 0;
                end else dly--;
            end
            if_ready = $urandom_range(0, 2) != 0;
            redirect_valid = $urandom_range(0, 15) == 0;
            redirect_addr = BASE + {22'd0, 8'($urandom_range(0, 63)), 2'b00};
            #1;
            acc = if_valid && if_ready;
            chk("r_pc_we", 32'(pc_we), 32'(redirect_valid || acc));
            if (redirect_valid || acc) chk("r_pc_imm", 32'(pc_imm), 32'(redirect_valid));
            if (redirect_valid) chk("r_target", pc_imm_addr, redirect_addr);
            if (if_valid) begin
                chk("r_if_pc", if_pc, exp_pc);
                chk("r_if_instr", if_instr, word_at(exp_pc));
            end
            if (imem_req) begin
                chk("r_one_outstanding", 32'(was_pending), 0);
                req_addr = pc; pending = 1; chk_addr = 1; dly = $urandom_range(0, 3);
            end
            if (redirect_valid) exp_pc = redirect_addr;
            else if (acc) begin
                exp_pc = exp_pc + 4;
                n_acc++;
            end
            if (pc_we) pc = pc_imm ? pc_imm_addr : pc + 4;
        end
        chk("r_progress", 32'(n_acc > 50), 1);
        chk("r_no_fault", 32'(fault), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
